// File: rtl/cp0_ctrl_v2.sv
// cp0_ctrl_v2: MIPS system-control coprocessor beside the M stage. It holds SR, Cause,
// EPC, PRId, Count, Compare and BadVAddr, arbitrates exceptions, hardware interrupts and
// the timer interrupt, and drives the trap and eret controls.
// Ports: clk/reset (async active-low); hwint; mtc0 write (we/waddr/wdata); mfc0 read
// (raddr/rdata, combinational); exception report (exc_*); eret; trap/epc/exl outputs.
module cp0_ctrl_v2 #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h19377059,
  parameter int          TIMER_EN  = 1,
  parameter int          COUNT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic [4:0]           raddr,
  output logic [31:0]          rdata,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic [31:0]          exc_badva,
  input  logic                 eret,
  output logic                 trap,
  output logic [31:0]          epc,
  output logic                 exl
);

  localparam logic [4:0]  A_BADVA   = 5'd8;
  localparam logic [4:0]  A_COUNT   = 5'd9;
  localparam logic [4:0]  A_COMPARE = 5'd11;
  localparam logic [4:0]  A_SR      = 5'd12;
  localparam logic [4:0]  A_CAUSE   = 5'd13;
  localparam logic [4:0]  A_EPC     = 5'd14;
  localparam logic [4:0]  A_PRID    = 5'd15;
  localparam logic [5:0]  HW_MASK   = 6'((1 << NUM_HWINT) - 1);
  // Only IM[10 +: NUM_HWINT], EXL and IE can ever hold a 1.
  localparam logic [31:0] SR_WMASK  = {16'd0, HW_MASK, 8'd0, 2'b11};
  localparam logic [3:0]  PRESC_MAX = 4'(COUNT_DIV - 1);
  localparam bit          TMR       = (TIMER_EN != 0);

  logic [31:0] sr;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] badva;
  logic [31:0] count;
  logic [31:0] compare;
  logic [3:0]  presc;
  logic        tpend;

  logic [5:0]  hw6;
  logic [5:0]  ip_live;
  logic        int_req;
  logic [4:0]  taken_code;
  logic [31:0] epc_next;
  logic        wr_ok;
  logic        count_wr;
  logic        presc_wrap;
  logic [31:0] count_inc;
  logic [31:0] cause_word;

  // The low PC bits are always replaced by the word-aligned EPC.
  wire unused_pc_bits = &{1'b0, exc_pc[1:0]};

  always_comb begin
    hw6 = '0;
    hw6[NUM_HWINT-1:0] = hwint;
  end

  // Interrupts are judged on the live lines, not the one-cycle-old Cause.IP copy.
  assign ip_live    = hw6 | {TMR & tpend, 5'd0};
  assign int_req    = (|(ip_live & sr[15:10])) & sr[0] & ~sr[1];
  assign trap       = (exc_req | int_req) & ~sr[1];
  assign taken_code = int_req ? 5'd0 : exc_code;
  assign epc_next   = exc_bd ? {exc_pc[31:2] - 30'd1, 2'b00} : {exc_pc[31:2], 2'b00};
  // An mtc0 only lands when neither trap nor eret claims the cycle.
  assign wr_ok      = we & ~trap & ~eret;
  assign count_wr   = wr_ok & (waddr == A_COUNT);
  assign presc_wrap = (presc == PRESC_MAX);
  assign count_inc  = count + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr        <= '0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
      badva     <= '0;
      count     <= '0;
      compare   <= '0;
      presc     <= '0;
      tpend     <= 1'b0;
    end else begin
      cause_ip <= hw6 | {TMR & tpend, 5'd0};

      if (TMR) begin
        if (count_wr) begin
          count <= wdata;
          presc <= '0;
        end else if (presc_wrap) begin
          count <= count_inc;
          presc <= '0;
        end else begin
          presc <= presc + 4'd1;
        end
        // A Compare write clears the pending timer even when a trap discards the write.
        if (we && waddr == A_COMPARE)
          tpend <= 1'b0;
        else if (presc_wrap && !count_wr && count_inc == compare && compare != 32'd0)
          tpend <= 1'b1;
        if (wr_ok && waddr == A_COMPARE)
          compare <= wdata;
      end

      if (trap) begin
        cause_exc <= taken_code;
        cause_bd  <= exc_bd;
        epc_q     <= epc_next;
        sr[1]     <= 1'b1;
        if (taken_code == 5'd4 || taken_code == 5'd5)
          badva <= exc_badva;
      end else if (eret) begin
        sr[1] <= 1'b0;
      end else if (we) begin
        case (waddr)
          A_SR:    sr    <= wdata & SR_WMASK;
          A_EPC:   epc_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};

  always_comb begin
    rdata = '0;
    case (raddr)
      A_BADVA:   rdata = badva;
      A_COUNT:   rdata = count;
      A_COMPARE: rdata = compare;
      A_SR:      rdata = sr;
      A_CAUSE:   rdata = cause_word;
      A_EPC:     rdata = epc_q;
      A_PRID:    rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

  assign epc = epc_q;
  assign exl = sr[1];

endmodule

// File: doc/cp0_ctrl_v2.md
Name: cp0_ctrl_v2

Overview:
- Parametrised system-control coprocessor for the 5-stage MIPS pipeline. Sits beside the M stage.
- Holds SR(12), Cause(13), EPC(14), PRId(15), plus new Count(9), Compare(11) and BadVAddr(8) registers.
- Arbitrates exceptions, hardware interrupts and an internal timer interrupt, then drives the trap and return controls.
- Compared with the previous generation, it adds a configurable interrupt-line count, a timer with a prescaler, BadVAddr capture and a defined event priority.

Parameters:
- NUM_HWINT, 6, number of external interrupt lines (1..6). They map to Cause.IP/SR.IM bits [10 +: NUM_HWINT]. Unused bits read 0.
- PRID_VAL, 32'h19377059, read-only PRId value.
- TIMER_EN, 1, 1 = Count/Compare implemented; 0 = both read 0 and the timer interrupt is tied 0.
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hwint  in  NUM_HWINT  level-sensitive external interrupt lines.
- we  in  1  mtc0 write enable (M stage).
- waddr  in  5  mtc0 destination register number.
- wdata  in  32  mtc0 data.
- raddr  in  5  mfc0 source register number.
- rdata  out  32  combinational read of the addressed register; 0 for unimplemented numbers.
- exc_req  in  1  an exception is reported by the pipeline for the current M-stage instruction.
- exc_code  in  5  ExcCode of the reported exception.
- exc_pc  in  32  PC of the faulting (or oldest live) instruction.
- exc_bd  in  1  the faulting instruction sits in a delay slot.
- exc_badva  in  32  faulting address; used for codes 4 and 5.
- eret  in  1  eret is committing.
- trap  out  1  combinational: the pipeline must flush and redirect to the handler this cycle.
- epc  out  32  current EPC, used by eret.
- exl  out  1  SR.EXL.

Behaviour:
- Reset (reset=0, asynchronous):
  - SR=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0, timer-pending=0.
  - Outputs: rdata follows raddr (PRId reads PRID_VAL); trap=0; epc=0; exl=0.
- SR writable bits: IM[10 +: NUM_HWINT], EXL[1], IE[0]. All other bits are written as 0. The Cause register is not writable by mtc0.
- Cause.IP is updated every clock:
  - IP[10 +: NUM_HWINT] = hwint sampled at that edge.
  - IP[15] is additionally ORed with timer-pending when TIMER_EN=1.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. Count increments (mod 2^32, wraps silently) when the prescaler wraps.
  - timer-pending is set on the edge where Count (after increment) == Compare and Compare != 0.
  - timer-pending is cleared by any mtc0 to Compare.
  - An mtc0 to Count loads Count and clears the prescaler.
- Interrupt request: int_req = |(IP_live & SR.IM) & SR.IE & ~SR.EXL.
  - IP_live = current hwint and timer-pending (combinational), not the registered Cause.IP.
- trap = (exc_req | int_req) & ~SR.EXL. Exceptions while EXL=1 are ignored; no nesting.
- Priority per clock edge, highest first:
  1. trap. Actions:
     - Cause.ExcCode = 0 if int_req, else exc_code.
     - Cause.BD[31] = exc_bd.
     - EPC = exc_bd ? {exc_pc[31:2]-1, 2'b00} : {exc_pc[31:2], 2'b00}.
     - SR.EXL = 1.
     - BadVAddr = exc_badva only if the taken code is 4 or 5.
  2. eret: SR.EXL = 0.
  3. we: normal mtc0 write.
  - A lower-priority event in the same cycle is discarded. Exception: an mtc0 to Compare coincident with a trap still clears timer-pending.
- Read-during-write: rdata shows the old value. The new value is visible the cycle after the edge.
- An interrupt beats a simultaneous exc_req. ExcCode is 0; the excepting instruction re-executes after eret.
- Reset mid-operation clears timer-pending and EXL immediately, without waiting for a clock edge.

Test Plan:
- Interrupt entry: reset release; mtc0 SR=32'h0000_0401; drive hwint[0]=1 while exc_pc=32'h0000_3010 -> trap=1 same cycle. After the edge: EPC=32'h3010, ExcCode=0, EXL=1, trap=0 while hwint stays 1.
- Delay-slot exception: exc_req=1, code=4, exc_bd=1, exc_pc=32'h3024, badva=32'h1001 -> EPC=32'h3020, Cause[31]=1, ExcCode=4, BadVAddr=32'h1001. Then eret -> EXL=0.
- Timer: COUNT_DIV=2; Compare=5; SR=32'h0000_8001 -> trap rises 10 clocks after the Compare write (Count reaches 5). mtc0 Compare=5 again -> pending cleared, Cause.IP[15]=0 one cycle later.
- Simultaneous events: trap and eret and mtc0 EPC=32'hDEAD_BEE0 in one cycle -> trap wins; EPC=exc_pc; EXL=1; write discarded.
- Masking and width: NUM_HWINT=2; write SR=32'hFFFF_FFFF -> rdata(12)=32'h0000_0C03. raddr=15 -> 32'h19377059. raddr=20 -> 0.
- Async reset: assert reset mid-handler with EXL=1, Count=32'h37 -> all registers zero before the next clk edge; trap=0.
